// File: rtl/fifo_controller_if.sv
// fifo_controller_if: groups the request/enable/status signals between the
// producer/consumer logic (master) and the FIFO pointer controller (slave).
//   master drives : wr_req, rd_req, flush, clr_err
//   master sees   : wr_en, wr_addr, rd_en, rd_addr, rd_valid,
//                   full, empty, almost_full, almost_empty, count,
//                   overflow, underflow
// A is the RAM address width; depth is 2^A and count is A+1 bits wide.
interface fifo_controller_if #(
  parameter int A = 4
);
  logic         wr_req;
  logic         rd_req;
  logic         flush;
  logic         clr_err;
  logic         wr_en;
  logic [A-1:0] wr_addr;
  logic         rd_en;
  logic [A-1:0] rd_addr;
  logic         rd_valid;
  logic         full;
  logic         empty;
  logic         almost_full;
  logic         almost_empty;
  logic [A:0]   count;
  logic         overflow;
  logic         underflow;

  modport master (
    output wr_req, rd_req, flush, clr_err,
    input  wr_en, wr_addr, rd_en, rd_addr, rd_valid,
           full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );

  modport slave (
    input  wr_req, rd_req, flush, clr_err,
    output wr_en, wr_addr, rd_en, rd_addr, rd_valid,
           full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );
endinterface

// File: rtl/fifo_controller.sv
// fifo_controller: single-clock FIFO pointer controller for an external
// 2^A-entry dual-port RAM with a synchronous read port.
// Ports:
//   clk  - clock, all state updates on the rising edge
//   rst  - synchronous active-high reset (highest priority)
//   bus  - fifo_controller_if.slave: requests in; RAM enables/addresses,
//          read-data-valid, occupancy, status flags and sticky errors out
// Parameters:
//   A        - address width; pointers are A+1 bits, MSB is the wrap bit
//   AF_LEVEL - almost_full when count >= AF_LEVEL (1..2^A)
//   AE_LEVEL - almost_empty when count <= AE_LEVEL (0..2^A-1)
module fifo_controller #(
  parameter int A        = 4,
  parameter int AF_LEVEL = (2 ** A) - 1,
  parameter int AE_LEVEL = 1
) (
  input logic               clk,
  input logic               rst,
  fifo_controller_if.slave  bus
);

  localparam logic [A:0] AF_L = (A + 1)'(AF_LEVEL);
  localparam logic [A:0] AE_L = (A + 1)'(AE_LEVEL);

  logic [A:0] wptr;
  logic [A:0] rptr;
  logic       rd_valid_q;
  logic       overflow_q;
  logic       underflow_q;

  logic       full_c;
  logic       empty_c;
  logic [A:0] count_c;
  logic       wr_en_c;
  logic       rd_en_c;
  logic       ovf_set;
  logic       udf_set;

  // Flags and count come from registered pointers only, so no request
  // ever reaches them combinationally; the equal-low-bits / different-MSB
  // test distinguishes full from empty.
  // NOTE: every always_comb output gets a value on every path (here all
  // are unconditional) so no latch can be inferred.
  always_comb begin
    empty_c = (wptr == rptr);
    full_c  = (wptr[A] != rptr[A]) && (wptr[A-1:0] == rptr[A-1:0]);
    count_c = wptr - rptr;
    wr_en_c = bus.wr_req & ~full_c  & ~bus.flush & ~rst;
    rd_en_c = bus.rd_req & ~empty_c & ~bus.flush & ~rst;
    ovf_set = bus.wr_req & full_c  & ~bus.flush;
    udf_set = bus.rd_req & empty_c & ~bus.flush;
  end

  // Pointers and read-valid. Flush and reset both collapse the FIFO to
  // empty at zero; rd_en is already masked by flush/rst, so rd_valid
  // naturally drops to 0 after either.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, matching the hardware.
  // NOTE: the RAM contents themselves are never reset; zeroing the pointers
  // makes every stale entry unreachable, which is all that is needed.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      wptr       <= '0;
      rptr       <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wptr       <= wptr + (A + 1)'(wr_en_c);
      rptr       <= rptr + (A + 1)'(rd_en_c);
      rd_valid_q <= rd_en_c;
    end
  end

  // Sticky errors survive flush; clr_err clears them, but a set condition
  // in the same cycle wins because it is applied last.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.clr_err) begin
        overflow_q  <= 1'b0;
        underflow_q <= 1'b0;
      end
      if (ovf_set) overflow_q  <= 1'b1;
      if (udf_set) underflow_q <= 1'b1;
    end
  end

  assign bus.wr_en        = wr_en_c;
  assign bus.rd_en        = rd_en_c;
  assign bus.wr_addr      = wptr[A-1:0];
  assign bus.rd_addr      = rptr[A-1:0];
  assign bus.rd_valid     = rd_valid_q;
  assign bus.full         = full_c;
  assign bus.empty        = empty_c;
  assign bus.count        = count_c;
  assign bus.almost_full  = (count_c >= AF_L);
  assign bus.almost_empty = (count_c <= AE_L);
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_controller.sv
// tb_fifo_controller: directed self-checking bench for fifo_controller with
// A=2 (depth 4), AF_LEVEL=3, AE_LEVEL=1. Inputs change 1 time unit after a
// rising edge; combinational enables are checked 1 unit later and
// registered state is checked 1 unit after the following edge.
module tb_fifo_controller;

  localparam int A = 2;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  fifo_controller_if #(.A(A)) bus ();

  fifo_controller #(
    .A        (A),
    .AF_LEVEL (3),
    .AE_LEVEL (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 unit past the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic r, input logic f,
                       input logic c);
    bus.wr_req  = w;
    bus.rd_req  = r;
    bus.flush   = f;
    bus.clr_err = c;
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // ---------------- reset held 2 cycles with requests active
    rst = 1'b1;
    drive(1, 1, 0, 0);
    check("rst_wr_en", bus.wr_en, 0);
    check("rst_rd_en", bus.rd_en, 0);
    step();
    check("rst_wr_en_c1", bus.wr_en, 0);
    check("rst_rd_en_c1", bus.rd_en, 0);
    step();
    check("rst_count", bus.count, 0);
    check("rst_empty", bus.empty, 1);
    check("rst_full", bus.full, 0);
    check("rst_ae", bus.almost_empty, 1);
    check("rst_af", bus.almost_full, 0);
    check("rst_ovf", bus.overflow, 0);
    check("rst_udf", bus.underflow, 0);
    check("rst_rd_valid", bus.rd_valid, 0);
    check("rst_wr_addr", bus.wr_addr, 0);
    check("rst_rd_addr", bus.rd_addr, 0);
    rst = 1'b0;

    // ---------------- fill: 4 writes then a rejected 5th
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 0);
      check("fill_wr_en", bus.wr_en, 1);
      check("fill_wr_addr", bus.wr_addr, i);
      step();
      check("fill_count", bus.count, i + 1);
      check("fill_empty", bus.empty, 0);
      check("fill_af", bus.almost_full, (i + 1 >= 3) ? 1 : 0);
      check("fill_full", bus.full, (i + 1 == 4) ? 1 : 0);
      check("fill_ae", bus.almost_empty, (i + 1 <= 1) ? 1 : 0);
    end
    drive(1, 0, 0, 0);
    check("ovf_wr_en", bus.wr_en, 0);
    check("ovf_pre", bus.overflow, 0);
    step();
    check("ovf_set", bus.overflow, 1);
    check("ovf_count", bus.count, 4);

    // ---------------- drain: 4 reads, rd_valid lags rd_en by one cycle
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 0);
      check("drain_rd_en", bus.rd_en, 1);
      check("drain_rd_addr", bus.rd_addr, i);
      check("drain_rd_valid_pre", bus.rd_valid, (i > 0) ? 1 : 0);
      step();
      check("drain_rd_valid", bus.rd_valid, 1);
      check("drain_count", bus.count, 3 - i);
    end
    check("drain_empty", bus.empty, 1);
    drive(0, 1, 0, 0);
    check("udf_rd_en", bus.rd_en, 0);
    step();
    check("udf_set", bus.underflow, 1);
    check("udf_rd_valid", bus.rd_valid, 0);
    check("udf_ovf_kept", bus.overflow, 1);

    // ---------------- clear errors, then build count=2
    drive(0, 0, 0, 1);
    step();
    check("clr_ovf", bus.overflow, 0);
    check("clr_udf", bus.underflow, 0);
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0, 0);
      step();
    end
    check("wrap_start_count", bus.count, 2);

    // ---------------- wrap-around: 10 write+read pairs at count=2
    for (int i = 0; i < 10; i++) begin
      drive(1, 1, 0, 0);
      check("wrap_wr_en", bus.wr_en, 1);
      check("wrap_rd_en", bus.rd_en, 1);
      check("wrap_wr_addr", bus.wr_addr, (2 + i) % 4);
      check("wrap_rd_addr", bus.rd_addr, i % 4);
      step();
      check("wrap_count", bus.count, 2);
      check("wrap_full", bus.full, 0);
      check("wrap_empty", bus.empty, 0);
    end

    // ---------------- simultaneous at full
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0, 0);
      step();
    end
    check("sf_full", bus.full, 1);
    drive(1, 1, 0, 0);
    check("sf_wr_en", bus.wr_en, 0);
    check("sf_rd_en", bus.rd_en, 1);
    check("sf_rd_addr", bus.rd_addr, 2);
    step();
    check("sf_count", bus.count, 3);
    check("sf_ovf", bus.overflow, 1);
    check("sf_udf", bus.underflow, 0);

    // ---------------- simultaneous at empty
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 0);
      step();
    end
    check("se_empty", bus.empty, 1);
    drive(1, 1, 0, 0);
    check("se_wr_en", bus.wr_en, 1);
    check("se_rd_en", bus.rd_en, 0);
    step();
    check("se_count", bus.count, 1);
    check("se_udf", bus.underflow, 1);

    // ---------------- flush with a read in flight at count=3
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0, 0);
      step();
    end
    drive(1, 1, 0, 0);
    step();
    check("fl_pre_count", bus.count, 3);
    check("fl_pre_rd_valid", bus.rd_valid, 1);
    drive(1, 1, 1, 0);
    check("fl_wr_en", bus.wr_en, 0);
    check("fl_rd_en", bus.rd_en, 0);
    step();
    check("fl_count", bus.count, 0);
    check("fl_empty", bus.empty, 1);
    check("fl_rd_valid", bus.rd_valid, 0);
    check("fl_wr_addr", bus.wr_addr, 0);
    check("fl_ovf", bus.overflow, 1);
    check("fl_udf", bus.underflow, 1);

    // ---------------- clr_err with a set condition in the same cycle
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 0);
      step();
    end
    check("ce_full", bus.full, 1);
    drive(1, 0, 0, 1);
    check("ce_wr_en", bus.wr_en, 0);
    step();
    check("ce_ovf_wins", bus.overflow, 1);
    check("ce_udf_cleared", bus.underflow, 0);

    // ---------------- reset mid-operation
    drive(0, 1, 0, 0);
    step();
    check("mr_pre_count", bus.count, 3);
    check("mr_pre_rd_addr", bus.rd_addr, 1);
    rst = 1'b1;
    drive(1, 1, 0, 0);
    check("mr_wr_en", bus.wr_en, 0);
    check("mr_rd_en", bus.rd_en, 0);
    step();
    check("mr_count", bus.count, 0);
    check("mr_ovf", bus.overflow, 0);
    check("mr_rd_addr", bus.rd_addr, 0);
    check("mr_empty", bus.empty, 1);
    rst = 1'b0;
    drive(0, 0, 0, 0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
